// File: rtl/mac_pkg.sv
// Shared types and constants for the sparse int8 MAC datapath.
// Four signed int8 lanes per 32-bit word; lane i occupies bits [8i+7:8i].
package mac_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACC   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int LANES  = 4;
    localparam int LANE_W = 8;
    localparam int PROD_W = 16;
    localparam int SUM_W  = 18;

    function automatic logic signed [LANE_W-1:0] lane(
        input logic [LANES*LANE_W-1:0] word,
        input int                      idx
    );
        return word[idx*LANE_W +: LANE_W];
    endfunction

endpackage

// File: rtl/lane_mult4.sv
// Four signed 8x8 multipliers, adder tree to an 18-bit lane sum, zero-weight popcount.
// Purely combinational (0 cycles); no flow control, the parent registers the outputs.
module lane_mult4
    import mac_pkg::*;
(
    input  logic [LANES*LANE_W-1:0] w_data,
    input  logic [LANES*LANE_W-1:0] a_data,
    output logic signed [SUM_W-1:0] sum,
    output logic [2:0]              zero_cnt
);

    logic signed [LANE_W-1:0] wl;
    logic signed [LANE_W-1:0] al;
    logic signed [PROD_W-1:0] prod;

    // Pruned lanes still multiply (to zero); they are only counted, never skipped.
    always_comb begin
        sum      = '0;
        zero_cnt = '0;
        wl       = '0;
        al       = '0;
        prod     = '0;
        for (int i = 0; i < LANES; i++) begin
            wl       = lane(w_data, i);
            al       = lane(a_data, i);
            prod     = PROD_W'(wl) * PROD_W'(al);
            sum      = sum + SUM_W'(prod);
            zero_cnt = zero_cnt + 3'(wl == '0);
        end
    end

endmodule

// File: rtl/sparse_mac_unit.sv
// Accumulates DEPTH four-lane int8 dot-product beats into one ACC_W-bit result.
// Latency: result_valid two cycles after the last beat; w_valid gaps stall the job, no timeout.
module sparse_mac_unit
    import mac_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int ACC_W = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    w_valid,
    input  logic [31:0]             w_data,
    input  logic [31:0]             a_data,
    output logic                    busy,
    output logic signed [ACC_W-1:0] result,
    output logic                    result_valid,
    output logic [7:0]              zero_lanes
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    state_t                  state;
    state_t                  state_nxt;
    logic [CNT_W-1:0]        beat_cnt;
    logic signed [SUM_W-1:0] lane_sum;
    logic signed [SUM_W-1:0] s1_sum;
    logic                    s1_vld;
    logic [2:0]              lane_zeros;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_nxt;
    logic [8:0]              zero_sum;
    logic                    beat;
    logic                    last_beat;

    lane_mult4 u_lane_mult4 (
        .w_data   (w_data),
        .a_data   (a_data),
        .sum      (lane_sum),
        .zero_cnt (lane_zeros)
    );

    assign beat      = (state == ACC) && w_valid;
    assign last_beat = beat && (beat_cnt == CNT_W'(DEPTH - 1));
    assign acc_nxt   = s1_vld ? acc + ACC_W'(s1_sum) : acc;
    assign zero_sum  = {1'b0, zero_lanes} + 9'(lane_zeros);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = ACC;
            ACC:     if (last_beat) state_nxt = DRAIN;
            DRAIN:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            beat_cnt     <= '0;
            s1_sum       <= '0;
            s1_vld       <= 1'b0;
            acc          <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            zero_lanes   <= '0;
        end else begin
            s1_vld       <= beat;
            result_valid <= (state == DRAIN);
            if (beat) begin
                s1_sum <= lane_sum;
            end
            if (state == IDLE && start) begin
                acc        <= '0;
                beat_cnt   <= '0;
                zero_lanes <= '0;
            end else begin
                acc <= acc_nxt;
                if (beat) begin
                    beat_cnt   <= beat_cnt + CNT_W'(1);
                    zero_lanes <= zero_sum[8] ? 8'hFF : zero_sum[7:0];
                end
            end
            // DRAIN folds the final stage-1 sum in on its way to the output.
            if (state == DRAIN) begin
                result <= acc_nxt;
            end
        end
    end

endmodule

// File: doc/sparse_mac_unit.md
# sparse_mac_unit

Downstream consumer of the weight SRAM stage. Takes one packed 32-bit weight word per beat (four signed int8 lanes, with sparsity-pruned lanes already zeroed) and multiplies it lane-wise against a packed 32-bit activation word. It accumulates the four-lane dot product over DEPTH beats and emits a single accumulated result with a one-cycle valid strobe. It also counts zero weight lanes so software can measure effective sparsity.

## Interface
- DEPTH, 4, weight beats per dot product (1..64)
- ACC_W, 32, accumulator/result width (≥ 18 + clog2(DEPTH))
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-low
- start  input  1  begin a new dot product; honoured only in IDLE
- w_valid  input  1  w_data/a_data beat valid this cycle
- w_data  input  32  four signed int8 weight lanes, lane i = bits [8i+7:8i]
- a_data  input  32  four signed int8 activation lanes, same packing
- busy  output  1  high in ACC and DRAIN
- result  output  ACC_W  signed accumulated dot product, held until next start
- result_valid  output  1  one-cycle pulse when result updates
- zero_lanes  output  8  zero weight lanes seen in current/last job, saturates at 255

## Operation
- Reset is asynchronous, active-low, clock clk. It applies state=IDLE, beat count=0, accumulator=0, stage-1 registers=0, result=0, result_valid=0, busy=0, zero_lanes=0.
- FSM states:
  - IDLE: on start, go to ACC. Clear the accumulator, the beat counter and zero_lanes. result keeps its old value.
  - ACC: each cycle with w_valid=1 is a beat. Stage 1 registers p_i = signed(w_i)·signed(a_i), 16 bits each, plus a stage-1 valid flag. zero_lanes += number of w_i == 0, saturating. The beat counter increments. On the DEPTH-th beat, go to DRAIN. If w_valid=0, nothing advances and there is no timeout.
  - DRAIN: exactly one cycle. The last stage-1 sum is added into the accumulator, result is loaded, result_valid=1, then go to IDLE.
- Stage 2: whenever the stage-1 valid flag is set, acc += sign-extend(p0+p1+p2+p3). The lane sum is 18 bits signed.
- Arithmetic: all signed two's complement. The accumulator wraps modulo 2^ACC_W with no saturation and no overflow flag.
- Ignored inputs: start while busy; w_valid in IDLE; w_valid in DRAIN, which is not counted and not multiplied.
- start and w_valid together in IDLE: start is taken, but that cycle's beat is not consumed. The first beat is the next w_valid in ACC.
- Zero lanes still produce a product of 0. The lane is not skipped; it is only counted.
- Reset mid-job aborts immediately. No result_valid is produced and all registers return to their reset values.

## Timing
- start is sampled at edge e, and busy goes high after e.
- When the last (DEPTH-th) beat is presented in cycle n:
  - result_valid is high, and result is valid, during cycle n+2.
  - busy is low from cycle n+2.
- Minimum job length is DEPTH+2 cycles from start to result_valid: the start cycle, DEPTH beat cycles, then the DRAIN edge.
- A new start is accepted in the cycle result_valid is high, since the state is IDLE. The next result_valid can come no earlier than DEPTH+2 cycles later.
- All outputs are registered. There are no combinational paths from input to output.

## Structure
- Shared package `mac_pkg`:
  - state enum (IDLE, ACC, DRAIN);
  - LANES=4, LANE_W=8, PROD_W=16, SUM_W=18;
  - lane-extract helper function.
- One sub-module `lane_mult4`: four signed 8×8 multipliers, adder tree to an 18-bit sum, and zero-lane popcount (0..4). It is purely combinational; its outputs are registered by the parent in stage 1.
- The parent holds the FSM, beat counter (clog2(DEPTH+1) bits), stage-1 register, accumulator, and output registers.

## Test plan
- Dense weights, sparse lanes: DEPTH=4, w_data=0x000027DC each beat (lanes −36, 39, 0, 0), a_data=0x01010101 → result=12, zero_lanes=8, result_valid exactly 2 cycles after the 4th beat.
- Negative accumulation: w_data=0x80808080, a_data=0x7F7F7F7F, 4 beats → result = 16·(−128·127) = −260096, all lanes nonzero so zero_lanes=0.
- Gapped beats: the same stimulus as the first scenario with w_valid deasserted 3 cycles between beats → identical result 12. busy stays high throughout, and no early result_valid.
- Protocol abuse:
  - w_valid pulses in IDLE → no counting.
  - start re-pulsed mid-job → ignored; result equals the undisturbed value.
  - start+w_valid in the same IDLE cycle → that beat is not counted.
- Reset mid-job: assert reset after 2 of 4 beats → all outputs 0 immediately, with no result_valid. A following clean job gives the correct result.
- Wrap/saturation: ACC_W=18, DEPTH=64, w_data=a_data=0x80808080 → result wraps modulo 2^18. Separately, 64 all-zero beats → zero_lanes saturates at 255 and result=0.
